adc_serial_capture: RTL and testbench

//  Downstream consumer of the ADC clock divider's ad_clk (registered, clk domain).

---
 rtl/adc_serial_capture.sv | 148 ++++++++++++++
 tb/tb_adc_serial_capture.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_serial_capture.sv
// Serial SAR ADC frame capture, paced by the divided ad_clk.
// Build option: define ADC_AVG_EN to average 2^AVG_LOG2 frames per sample.
module adc_serial_capture #(
    parameter int DATA_W     = 12,
    parameter int LEAD_CLKS  = 2,
    parameter int FRAME_CLKS = 16,
    parameter int IDLE_CLKS  = 1,
    parameter int AVG_LOG2   = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ad_clk,
    input  logic              en,
    output logic              adc_cs_n,
    output logic              adc_sclk,
    input  logic              adc_dout,
    output logic [DATA_W-1:0] sample_data,
    output logic              sample_valid,
    input  logic              sample_ready,
    output logic              overrun,
    input  logic              ovr_clr
);

    localparam int BW = $clog2(FRAME_CLKS + 1);
    localparam int IW = $clog2(IDLE_CLKS + 1);
    localparam logic [BW-1:0] FIRST_BIT = BW'(LEAD_CLKS);
    localparam logic [BW-1:0] END_BIT   = BW'(LEAD_CLKS + DATA_W);
    localparam logic [BW-1:0] LAST_BIT  = BW'(FRAME_CLKS - 1);
    localparam logic [IW-1:0] IDLE_MAX  = IW'(IDLE_CLKS);

    if (LEAD_CLKS + DATA_W > FRAME_CLKS || IDLE_CLKS < 1 || AVG_LOG2 < 1) begin : g_bad_cfg
        $error("adc_serial_capture: frame layout does not fit");
    end

    typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

    state_t            state;
    logic              ad_q;
    logic              rise;
    logic [BW-1:0]     bit_cnt;
    logic [IW-1:0]     idle_cnt;
    logic [DATA_W-1:0] shreg;
    logic [DATA_W-1:0] cap;
    logic              deliver;
    logic              drop;

`ifdef ADC_AVG_EN
    localparam int AW = DATA_W + AVG_LOG2;
    logic [AW-1:0]       acc;
    logic [AW-1:0]       acc_sum;
    logic [AVG_LOG2-1:0] avg_cnt;

    assign acc_sum = acc + AW'(shreg);
`endif

    assign rise = ad_clk & ~ad_q;
    assign drop = deliver & sample_valid & ~sample_ready;

    // Frame sequencer: chip select, sclk and bit capture, stepped on ad_clk rises.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            ad_q     <= 1'b0;
            adc_cs_n <= 1'b1;
            adc_sclk <= 1'b0;
            bit_cnt  <= '0;
            idle_cnt <= '0;
            shreg    <= '0;
            cap      <= '0;
            deliver  <= 1'b0;
`ifdef ADC_AVG_EN
            acc      <= '0;
            avg_cnt  <= '0;
`endif
        end else begin
            ad_q    <= ad_clk;
            deliver <= 1'b0;
            unique case (state)
                IDLE: begin
                    adc_cs_n <= 1'b1;
                    adc_sclk <= 1'b0;
                    if (rise) begin
                        if (en && idle_cnt == IDLE_MAX) begin
                            adc_cs_n <= 1'b0;
                            bit_cnt  <= '0;
                            state    <= CONV;
                        end else if (idle_cnt != IDLE_MAX) begin
                            idle_cnt <= idle_cnt + IW'(1);
                        end
                    end
                end
                CONV: begin
                    // sclk follows ad_clk, but only from the first counted rise on
                    adc_sclk <= ad_clk & (adc_sclk | rise);
                    if (rise) begin
                        if (bit_cnt >= FIRST_BIT && bit_cnt < END_BIT) begin
                            shreg <= {shreg[DATA_W-2:0], adc_dout};
                        end
                        bit_cnt <= bit_cnt + BW'(1);
                        if (bit_cnt == LAST_BIT) begin
                            state <= DONE;
                        end
                    end
                end
                DONE: begin
                    adc_cs_n <= 1'b1;
                    adc_sclk <= 1'b0;
                    idle_cnt <= '0;
                    state    <= IDLE;
`ifdef ADC_AVG_EN
                    avg_cnt <= avg_cnt + AVG_LOG2'(1);
                    if (&avg_cnt) begin
                        deliver <= 1'b1;
                        cap     <= DATA_W'(acc_sum >> AVG_LOG2);
                        acc     <= '0;
                    end else begin
                        acc <= acc_sum;
                    end
`else
                    deliver <= 1'b1;
                    cap     <= shreg;
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

    // One-deep output register; a sample arriving while it is still full is dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sample_data  <= '0;
            sample_valid <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            if (deliver) begin
                if (!sample_valid || sample_ready) begin
                    sample_data  <= cap;
                    sample_valid <= 1'b1;
                end
            end else if (sample_ready) begin
                sample_valid <= 1'b0;
            end
            overrun <= drop | (overrun & ~ovr_clr);
        end
    end

endmodule

// File: tb/tb_adc_serial_capture.sv
// Scoreboard bench for adc_serial_capture with a behavioural serial ADC.
// Define ADC_AVG_EN to exercise the averaging build instead of the raw build.
`timescale 1ns/1ps
module tb_adc_serial_capture;

    localparam int DW = 12;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          ad_clk = 1'b0;
    logic          en = 1'b0;
    logic          adc_cs_n;
    logic          adc_sclk;
    logic          adc_dout = 1'b0;
    logic [DW-1:0] sample_data;
    logic          sample_valid;
    logic          sample_ready = 1'b0;
    logic          overrun;
    logic          ovr_clr = 1'b0;

    typedef struct {
        string name;
        int    act;
        int    exp;
    } chk_t;

    chk_t          chk_q[$];
    chk_t          c;
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] frame_q[$];
    int            n_cmp = 0;
    int            n_bad = 0;
    int            nrise = 0;
    bit            in_frame = 1'b0;
    bit            sclk_q = 1'b0;
    bit            abort = 1'b0;
    logic [DW-1:0] cur = '0;
    logic [15:0]   word = '0;
    logic [2:0]    div = '0;

    adc_serial_capture dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ad_clk       (ad_clk),
        .en           (en),
        .adc_cs_n     (adc_cs_n),
        .adc_sclk     (adc_sclk),
        .adc_dout     (adc_dout),
        .sample_data  (sample_data),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .overrun      (overrun),
        .ovr_clr      (ovr_clr)
    );

    always #5 clk = ~clk;

    // divide-by-8 ad_clk, changed away from the active edge
    always @(negedge clk) begin
        div    = div + 3'd1;
        ad_clk = div[2];
    end

    task automatic cmp(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // monitor + ADC model: the only process that compares
    always @(negedge clk) begin
        while (chk_q.size() > 0) begin
            c = chk_q.pop_front();
            cmp(c.name, c.act, c.exp);
        end
        if (sample_valid && sample_ready) begin
            if (exp_q.size() == 0)
                cmp("unexpected_sample", int'(sample_data), -1);
            else
                cmp("sample_data", int'(sample_data), int'(exp_q.pop_front()));
        end
        if (adc_cs_n) begin
            if (in_frame && !abort)
                cmp("sclk_rises", nrise, 16);
            in_frame = 1'b0;
            nrise    = 0;
        end else begin
            if (!in_frame) begin
                in_frame = 1'b1;
                cur = (frame_q.size() > 0) ? frame_q.pop_front() : '0;
            end
            if (adc_sclk && !sclk_q)
                nrise++;
        end
        sclk_q   = adc_sclk;
        word     = {2'b00, cur, 2'b00};
        adc_dout = (nrise < 16) ? word[15-nrise] : 1'b0;
    end

    task automatic probe(input string name, input int act, input int exp);
        chk_t p;
        p.name = name;
        p.act  = act;
        p.exp  = exp;
        chk_q.push_back(p);
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic wait_cs(input logic level, input string what);
        logic prev;
        bit   seen;
        prev = adc_cs_n;
        seen = 1'b0;
        for (int i = 0; i < 3000 && !seen; i++) begin
            @(posedge clk);
            #2;
            if (adc_cs_n == level && prev != level)
                seen = 1'b1;
            prev = adc_cs_n;
        end
        if (!seen)
            probe({"timeout_", what}, 0, 1);
    endtask

    task automatic wait_nrise(input int n);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 3000 && !seen; i++) begin
            @(posedge clk);
            #2;
            if (nrise >= n)
                seen = 1'b1;
        end
        if (!seen)
            probe("timeout_nrise", 0, 1);
    endtask

    task automatic run_frames(input int n);
        en = 1'b1;
        for (int k = 0; k < n; k++)
            wait_cs(1'b0, "frame_start");
        en = 1'b0;
        wait_cs(1'b1, "frame_end");
    endtask

    initial begin
        int lows;

        // reset with ad_clk running
        tick(20);
        probe("rst_cs_n", int'(adc_cs_n), 1);
        probe("rst_sclk", int'(adc_sclk), 0);
        probe("rst_valid", int'(sample_valid), 0);
        probe("rst_overrun", int'(overrun), 0);
        probe("rst_data", int'(sample_data), 0);
        rst_n = 1'b1;
        tick(4);

`ifdef ADC_AVG_EN
        sample_ready = 1'b1;
        frame_q.push_back(12'd100);
        frame_q.push_back(12'd102);
        frame_q.push_back(12'd104);
        frame_q.push_back(12'd106);
        exp_q.push_back(12'd103);
        run_frames(4);
        tick(4);
        frame_q.push_back(12'd1);
        frame_q.push_back(12'd1);
        frame_q.push_back(12'd1);
        frame_q.push_back(12'd2);
        exp_q.push_back(12'd1);
        run_frames(4);
        tick(4);
        probe("avg_overrun", int'(overrun), 0);
`else
        // single frame, ready high
        sample_ready = 1'b1;
        frame_q.push_back(12'hA5C);
        exp_q.push_back(12'hA5C);
        run_frames(1);
        tick(1);
        probe("t2_valid_lat2", int'(sample_valid), 1);
        probe("t2_data", int'(sample_data), 'hA5C);
        tick(1);
        probe("t2_valid_one_clk", int'(sample_valid), 0);

        // backpressure across two frames
        sample_ready = 1'b0;
        frame_q.push_back(12'h123);
        frame_q.push_back(12'h456);
        exp_q.push_back(12'h123);
        run_frames(2);
        tick(3);
        probe("t3_data_held", int'(sample_data), 'h123);
        probe("t3_valid_held", int'(sample_valid), 1);
        probe("t3_overrun_set", int'(overrun), 1);
        ovr_clr = 1'b1;
        tick(1);
        ovr_clr = 1'b0;
        probe("t3_overrun_clr", int'(overrun), 0);
        probe("t3_data_after_clr", int'(sample_data), 'h123);
        sample_ready = 1'b1;
        tick(2);
        probe("t3_valid_drained", int'(sample_valid), 0);

        // ready rises exactly in frame 2's deliver cycle
        sample_ready = 1'b0;
        frame_q.push_back(12'h321);
        frame_q.push_back(12'h654);
        exp_q.push_back(12'h321);
        exp_q.push_back(12'h654);
        en = 1'b1;
        wait_cs(1'b0, "t4_a");
        wait_cs(1'b0, "t4_b");
        en = 1'b0;
        wait_cs(1'b1, "t4_end");
        sample_ready = 1'b1;
        tick(1);
        probe("t4_valid_held", int'(sample_valid), 1);
        probe("t4_data_new", int'(sample_data), 'h654);
        probe("t4_no_overrun", int'(overrun), 0);
        tick(2);
        probe("t4_valid_drained", int'(sample_valid), 0);

        // en dropped mid-frame
        frame_q.push_back(12'h0F0);
        exp_q.push_back(12'h0F0);
        en = 1'b1;
        wait_cs(1'b0, "t5_start");
        wait_nrise(5);
        en = 1'b0;
        wait_cs(1'b1, "t5_end");
        lows = 0;
        for (int i = 0; i < 400; i++) begin
            tick(1);
            if (!adc_cs_n)
                lows++;
        end
        probe("t5_cs_stays_high", lows, 0);

        // reset mid-frame
        frame_q.push_back(12'h777);
        en = 1'b1;
        wait_cs(1'b0, "t5r_start");
        en = 1'b0;
        wait_nrise(8);
        abort = 1'b1;
        rst_n = 1'b0;
        #1;
        probe("t5_rst_cs_at_once", int'(adc_cs_n), 1);
        probe("t5_rst_sclk", int'(adc_sclk), 0);
        tick(3);
        rst_n = 1'b1;
        tick(300);
        probe("t5_no_sample", int'(sample_valid), 0);
        abort = 1'b0;
`endif

        probe("exp_q_empty", exp_q.size(), 0);
        tick(3);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
